// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter with in-order queue feeding the register bank write port.
// Optional: define REGFILE_XZR_DISCARD_EN to handshake but drop writes to register 31.
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req0_valid,
    input  logic [AW-1:0]            req0_addr,
    input  logic [DW-1:0]            req0_data,
    output logic                     req0_ready,
    input  logic                     req1_valid,
    input  logic [AW-1:0]            req1_addr,
    input  logic [DW-1:0]            req1_data,
    output logic                     req1_ready,
    input  logic                     wr_hold,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    mem_addr [DEPTH];
    logic [DW-1:0]    mem_data [DEPTH];
    logic [DEPTH-1:0] occ, occ_next;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic             last_grant;
    logic             full, empty;
    logic             grant0, grant1, accept, push, pop;
    logic [AW-1:0]    push_addr;
    logic [DW-1:0]    push_data;
    logic [31:0]      mask_next;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign grant0 = req0_valid & (~req1_valid | last_grant);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant);

    assign req0_ready = grant0 & ~full & rst_n;
    assign req1_ready = grant1 & ~full & rst_n;

    assign accept    = req0_ready | req1_ready;
    assign push_addr = req1_ready ? req1_addr : req0_addr;
    assign push_data = req1_ready ? req1_data : req0_data;

`ifdef REGFILE_XZR_DISCARD_EN
    assign push = accept & (push_addr != AW'(31));
`else
    assign push = accept;
`endif

    assign wr_en   = ~empty & ~wr_hold;
    assign pop     = wr_en;
    assign wr_addr = empty ? '0 : mem_addr[rd_ptr];
    assign wr_data = empty ? '0 : mem_data[rd_ptr];

    // Mask is rebuilt from the post-edge occupancy, so a same-edge push/pop of one register needs no special case.
    always_comb begin
        occ_next = occ;
        if (pop)
            occ_next[rd_ptr] = 1'b0;
        if (push)
            occ_next[wr_ptr] = 1'b1;
        mask_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (occ_next[i]) begin
                if (push && (wr_ptr == PW'(i)))
                    mask_next = mask_next | (32'd1 << push_addr);
                else
                    mask_next = mask_next | (32'd1 << mem_addr[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            occ          <= '0;
            last_grant   <= 1'b1;
            pending_mask <= '0;
        end else begin
            if (accept)
                last_grant <= req1_ready;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            occ          <= occ_next;
            pending_mask <= mask_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

endmodule
